// File: rtl/sad_row_accumulator.sv
`timescale 1ns/1ps
// SAD row accumulator: sums one row of PE abs_out lanes per beat, builds
// per-candidate SADs and tracks the minimum over a block search.
module sad_row_accumulator #(
    parameter int PIXEL    = 8,
    parameter int NUM_PE   = 8,
    parameter int ROWS     = 8,
    parameter int NUM_CAND = 4,
    parameter int SAD_W    = PIXEL + $clog2(NUM_PE * ROWS),
    parameter int CAND_W   = $clog2(NUM_CAND)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    blk_start,
    input  logic [NUM_PE*PIXEL-1:0] abs_in,
    input  logic                    abs_valid,
    output logic [SAD_W-1:0]        sad_out,
    output logic [CAND_W-1:0]       sad_cand,
    output logic                    sad_valid,
    output logic [SAD_W-1:0]        best_sad,
    output logic [CAND_W-1:0]       best_cand,
    output logic                    best_valid,
    output logic                    busy
);

    localparam int RS_W  = PIXEL + $clog2(NUM_PE);
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

    localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(ROWS - 1);
    localparam logic [CAND_W-1:0] CAND_LAST = CAND_W'(NUM_CAND - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_DONE
    } state_t;

    state_t              r_state;
    logic [ROW_W-1:0]    r_row_cnt;
    logic [CAND_W-1:0]   r_cand_cnt;
    logic                r_in_done;
    logic                r_s1_valid;
    logic                r_s1_last;
    logic [CAND_W-1:0]   r_s1_cand;
    logic [SAD_W-1:0]    r_row_sum;
    logic [SAD_W-1:0]    r_acc;
    logic [SAD_W-1:0]    r_sad_out;
    logic [CAND_W-1:0]   r_sad_cand;
    logic                r_sad_valid;
    logic [SAD_W-1:0]    r_best_sad;
    logic [CAND_W-1:0]   r_best_cand;
    logic                r_best_valid;

    logic [RS_W-1:0]     w_row_sum;
    logic                w_take;
    logic                w_row_last;
    logic [SAD_W-1:0]    w_sad_new;

    // Adder tree over the PE lanes of the current beat
    always_comb begin
        w_row_sum = '0;
        for (int k = 0; k < NUM_PE; k++) begin
            w_row_sum = w_row_sum + RS_W'(abs_in[k*PIXEL +: PIXEL]);
        end
    end

    // A beat is consumed only while searching, not on a restart, and
    // only until the final candidate's last row has been taken
    assign w_take     = (r_state == S_ACCUM) && abs_valid
                        && !blk_start && !r_in_done;
    assign w_row_last = (r_row_cnt == ROW_LAST);
    assign w_sad_new  = r_acc + r_row_sum;

    // Stage 1: register the row sum with its row/candidate position
    always_ff @(posedge clk) begin
        if (rst) begin
            r_row_cnt  <= '0;
            r_cand_cnt <= '0;
            r_in_done  <= 1'b0;
            r_s1_valid <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_cand  <= '0;
            r_row_sum  <= '0;
        end else if (blk_start) begin
            r_row_cnt  <= '0;
            r_cand_cnt <= '0;
            r_in_done  <= 1'b0;
            r_s1_valid <= 1'b0;
        end else begin
            r_s1_valid <= w_take;
            if (w_take) begin
                r_row_sum <= SAD_W'(w_row_sum);
                r_s1_last <= w_row_last;
                r_s1_cand <= r_cand_cnt;
                if (w_row_last) begin
                    r_row_cnt  <= '0;
                    r_cand_cnt <= r_cand_cnt + 1'b1;
                    r_in_done  <= (r_cand_cnt == CAND_LAST);
                end else begin
                    r_row_cnt <= r_row_cnt + 1'b1;
                end
            end
        end
    end

    // Control FSM plus stage 2: accumulate rows, emit SADs, track minimum
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_acc        <= '0;
            r_sad_out    <= '0;
            r_sad_cand   <= '0;
            r_sad_valid  <= 1'b0;
            r_best_sad   <= '1;
            r_best_cand  <= '0;
            r_best_valid <= 1'b0;
        end else begin
            r_sad_valid  <= 1'b0;
            // The DONE pulse goes out even if a new search starts now
            r_best_valid <= (r_state == S_DONE);
            if (blk_start) begin
                r_state     <= S_ACCUM;
                r_acc       <= '0;
                r_best_sad  <= '1;
                r_best_cand <= '0;
            end else begin
                unique case (r_state)
                    S_IDLE: begin
                        r_state <= S_IDLE;
                    end
                    S_ACCUM: begin
                        if (r_s1_valid) begin
                            if (!r_s1_last) begin
                                r_acc <= w_sad_new;
                            end else begin
                                r_acc       <= '0;
                                r_sad_out   <= w_sad_new;
                                r_sad_cand  <= r_s1_cand;
                                r_sad_valid <= 1'b1;
                                // Strict compare keeps the lower index on ties
                                if (w_sad_new < r_best_sad) begin
                                    r_best_sad  <= w_sad_new;
                                    r_best_cand <= r_s1_cand;
                                end
                                if (r_s1_cand == CAND_LAST) begin
                                    r_state <= S_DONE;
                                end
                            end
                        end
                    end
                    S_DONE: begin
                        r_state <= S_IDLE;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign sad_out    = r_sad_out;
    assign sad_cand   = r_sad_cand;
    assign sad_valid  = r_sad_valid;
    assign best_sad   = r_best_sad;
    assign best_cand  = r_best_cand;
    assign best_valid = r_best_valid;
    assign busy       = (r_state == S_ACCUM);

endmodule
